// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared definitions for the nibble-serial subtractor: stage width and
// controller state encoding.
package sub_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bus of the nibble-serial
// subtractor. The controller is the master, the subtractor is the slave.
interface nibble_serial_subtractor_if
    import sub_pkg::*;
#(
    parameter int NIBBLES = 4
);

    localparam int W = NIBBLE_W * NIBBLES;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         overflow;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, overflow
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, overflow
    );

endinterface

// File: rtl/signed_four_bit_subtractor.sv
// Combinational one-nibble subtractor: diff = a - b - bin (mod 16), with
// the unsigned borrow-out so nibbles can be chained through a register.
module signed_four_bit_subtractor
    import sub_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a_i,
    input  logic [NIBBLE_W-1:0] b_i,
    input  logic                bin_i,
    output logic [NIBBLE_W-1:0] diff_o,
    output logic                bout_o
);

    logic [NIBBLE_W:0] full;

    // The extra top bit goes to 1 exactly when a < b + bin, i.e. the borrow.
    assign full            = {1'b0, a_i} - {1'b0, b_i} - {{NIBBLE_W{1'b0}}, bin_i};
    assign {bout_o, diff_o} = full;

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Wide A - B - bin computed over NIBBLES cycles with a single shared 4-bit
// stage, least-significant nibble first, behind a start/busy/done handshake.
module nibble_serial_subtractor
    import sub_pkg::*;
#(
    parameter int NIBBLES = 4
)(
    input  logic                        clk,
    input  logic                        rst,
    nibble_serial_subtractor_if.slave   bus
);

    localparam int                W     = NIBBLE_W * NIBBLES;
    localparam int                CNT_W = $clog2(NIBBLES);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(NIBBLES - 1);

    state_e             state_q, state_d;
    logic [W-1:0]       opa_q, opb_q, res_q, diff_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               borrow_q, a_msb_q, b_msb_q;
    logic               bout_q, ovf_q, done_q;
    logic               load, step, finish;
    logic [NIBBLE_W-1:0] st_diff;
    logic               st_bout;

    signed_four_bit_subtractor u_stage (
        .a_i    (opa_q[NIBBLE_W-1:0]),
        .b_i    (opb_q[NIBBLE_W-1:0]),
        .bin_i  (borrow_q),
        .diff_o (st_diff),
        .bout_o (st_bout)
    );

    always_comb begin
        // NOTE: every output of this block is given a default first, so no
        // path through the case leaves a value held and no latch is inferred.
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt_q == LAST) state_d = DONE;
            end
            DONE: begin
                finish  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: registers are written with non-blocking assignments so every
    // flop samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa_q    <= '0;
            opb_q    <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= finish;
            if (load) begin
                opa_q    <= bus.a;
                opb_q    <= bus.b;
                res_q    <= '0;
                cnt_q    <= '0;
                borrow_q <= bus.bin;
                a_msb_q  <= bus.a[W-1];
                b_msb_q  <= bus.b[W-1];
            end
            if (step) begin
                // Each stage result enters at the top; after NIBBLES shifts
                // the first (least-significant) nibble sits at the bottom.
                res_q    <= {st_diff, res_q[W-1:NIBBLE_W]};
                borrow_q <= st_bout;
                opa_q    <= opa_q >> NIBBLE_W;
                opb_q    <= opb_q >> NIBBLE_W;
                cnt_q    <= cnt_q + 1'b1;
            end
            if (finish) begin
                diff_q <= res_q;
                bout_q <= borrow_q;
                ovf_q  <= (a_msb_q != b_msb_q) && (res_q[W-1] != a_msb_q);
            end
        end
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.diff     = diff_q;
    assign bus.bout     = bout_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed bench for nibble_serial_subtractor (NIBBLES=4): latency, borrow
// ripple, signed overflow, start masking, async reset and back-to-back runs.
module tb_nibble_serial_subtractor;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;
    localparam int MAX_WAIT = 20;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    nibble_serial_subtractor_if #(.NIBBLES(NIBBLES)) bus ();

    nibble_serial_subtractor #(.NIBBLES(NIBBLES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands with start for exactly one sampling edge.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        bus.a     = a;
        bus.b     = b;
        bus.bin   = bin;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Count edges until done is seen, bounded by MAX_WAIT.
    task automatic wait_done(output int n, output bit seen);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < MAX_WAIT) begin
            tick();
            n++;
            if (bus.done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic expect_result(input string name, input logic [W-1:0] d,
                                 input logic bo, input logic ov);
        vectors++;
        if (bus.diff !== d || bus.bout !== bo || bus.overflow !== ov) begin
            miscompares++;
            $display("FAIL %s: diff=%h bout=%b ovf=%b, wanted diff=%h bout=%b ovf=%b",
                     name, bus.diff, bus.bout, bus.overflow, d, bo, ov);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if ({bus.busy, bus.done, bus.diff, bus.bout, bus.overflow} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: busy=%b done=%b diff=%h bout=%b ovf=%b, wanted all 0",
                     bus.busy, bus.done, bus.diff, bus.bout, bus.overflow);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int n;
        bit seen;
        launch(16'h1234, 16'h0234, 1'b0);
        vectors++;
        if (bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_busy: busy=%b, wanted 1", bus.busy);
        end
        wait_done(n, seen);
        vectors++;
        if (!seen || n != 5) begin
            miscompares++;
            $display("FAIL basic_latency: seen=%0d edges=%0d, wanted done 5 edges after start", seen, n);
        end
        expect_result("basic", 16'h1000, 1'b0, 1'b0);
        tick();
        vectors++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.diff !== 16'h1000) begin
            miscompares++;
            $display("FAIL basic_after: done=%b busy=%b diff=%h, wanted done=0 busy=0 diff=1000",
                     bus.done, bus.busy, bus.diff);
        end
    endtask

    task automatic test_ripple();
        int n;
        bit seen;
        launch(16'h0000, 16'h0001, 1'b0);
        wait_done(n, seen);
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL ripple_timeout: done=%b, wanted 1", bus.done);
        end
        expect_result("ripple", 16'hFFFF, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_overflow();
        int n;
        bit seen;
        launch(16'h8000, 16'h0001, 1'b0);
        wait_done(n, seen);
        expect_result("ovf_neg_minus_pos", 16'h7FFF, 1'b0, 1'b1);
        tick();
        launch(16'h7FFF, 16'hFFFF, 1'b0);
        wait_done(n, seen);
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL ovf_timeout: done=%b, wanted 1", bus.done);
        end
        expect_result("ovf_pos_minus_neg", 16'h8000, 1'b1, 1'b1);
        tick();
    endtask

    task automatic test_start_ignored();
        int n;
        bit seen;
        launch(16'h0005, 16'h0003, 1'b1);
        tick();
        // Outputs must still show the previous completion while running.
        expect_result("hold_during_run", 16'h8000, 1'b1, 1'b1);
        bus.a     = 16'hFFFF;
        bus.b     = 16'h0000;
        bus.bin   = 1'b0;
        bus.start = 1'b1;
        tick();
        tick();
        bus.start = 1'b0;
        wait_done(n, seen);
        vectors++;
        if (!seen || n != 2) begin
            miscompares++;
            $display("FAIL ignore_latency: seen=%0d edges=%0d, wanted 2", seen, n);
        end
        expect_result("ignore_start", 16'h0001, 1'b0, 1'b0);
        tick();
        tick();
        vectors++;
        if (bus.busy !== 1'b0 || bus.diff !== 16'h0001) begin
            miscompares++;
            $display("FAIL ignore_no_requeue: busy=%b diff=%h, wanted busy=0 diff=0001",
                     bus.busy, bus.diff);
        end
    endtask

    task automatic test_mid_reset();
        int n;
        bit seen;
        launch(16'h1234, 16'h0001, 1'b0);
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({bus.busy, bus.done, bus.diff, bus.bout, bus.overflow} !== '0) begin
            miscompares++;
            $display("FAIL mid_reset: busy=%b done=%b diff=%h bout=%b ovf=%b, wanted all 0",
                     bus.busy, bus.done, bus.diff, bus.bout, bus.overflow);
        end
        tick();
        rst = 1'b0;
        tick();
        launch(16'h00FF, 16'h000F, 1'b0);
        wait_done(n, seen);
        vectors++;
        if (!seen || n != 5) begin
            miscompares++;
            $display("FAIL post_reset_latency: seen=%0d edges=%0d, wanted 5", seen, n);
        end
        expect_result("post_reset", 16'h00F0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] va [3];
        logic [W-1:0] vb [3];
        logic [W-1:0] vd [3];
        logic [W-1:0] held;
        int n;
        va = '{16'h1234, 16'h0000, 16'hABCD};
        vb = '{16'h0234, 16'h0001, 16'h1111};
        vd = '{16'h1000, 16'hFFFF, 16'h9ABC};
        held = 16'h00F0;
        bus.a     = va[0];
        bus.b     = vb[0];
        bus.bin   = 1'b0;
        bus.start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n = 0;
            do begin
                tick();
                n++;
                if (bus.done !== 1'b1) begin
                    vectors++;
                    if (bus.diff !== held) begin
                        miscompares++;
                        $display("FAIL b2b_hold[%0d]: diff=%h, wanted %h", i, bus.diff, held);
                    end
                end
            end while (bus.done !== 1'b1 && n < MAX_WAIT);
            vectors++;
            if (n != 6) begin
                miscompares++;
                $display("FAIL b2b_period[%0d]: edges=%0d, wanted 6", i, n);
            end
            vectors++;
            if (bus.diff !== vd[i]) begin
                miscompares++;
                $display("FAIL b2b_diff[%0d]: diff=%h, wanted %h", i, bus.diff, vd[i]);
            end
            held = vd[i];
            if (i < 2) begin
                bus.a = va[i+1];
                bus.b = vb[i+1];
            end else begin
                bus.start = 1'b0;
            end
        end
        tick();
        tick();
        vectors++;
        if (bus.busy !== 1'b0 || bus.diff !== 16'h9ABC) begin
            miscompares++;
            $display("FAIL b2b_end: busy=%b diff=%h, wanted busy=0 diff=9abc", bus.busy, bus.diff);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.a       = '0;
        bus.b       = '0;
        bus.bin     = 1'b0;
        test_reset();
        test_basic();
        test_ripple();
        test_overflow();
        test_start_ignored();
        test_mid_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
